demux_1to4: RTL and testbench

DEMUX_1TO4 -- requirements
Module: demux_1to4

---
 rtl/demux_pkg.sv | 14 +
 rtl/demux_chan_buf.sv | 54 +++++
 rtl/demux_1to4.sv | 48 ++++
 tb/tb_demux_1to4.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and slice helper for the 1-to-4 demux
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // Low bit of channel ch inside a flattened bus of w-bit lanes.
  function automatic int ch_lsb(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/demux_chan_buf.sv
// rtl/demux_chan_buf.sv - one-entry channel holding buffer with drain counter
module demux_chan_buf #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_fire;

  assign rd_fire = full_q && rd_ready;

  // A write on the same edge as a drain wins, so the buffer stays full with no bubble.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (rd_fire) begin
      full_d = 1'b0;
      cnt_d  = cnt_q + CNT_W'(1);
    end
    if (wr_en) begin
      full_d = 1'b1;
      data_d = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign full = full_q;
  assign data = data_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/demux_1to4.sv
// rtl/demux_1to4.sv - routes one input stream to four independently drained channels
module demux_1to4
  import demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        in_data,
  input  sel_t                    in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*CNT_W-1:0] xfer_cnt
);

  logic [NUM_CH-1:0] wr_en;

  // Only the addressed channel gates acceptance; other stalled channels never block.
  assign in_ready = !rst && (!out_valid[in_sel] || out_ready[in_sel]);

  always_comb begin
    wr_en = '0;
    if (in_valid && in_ready) begin
      wr_en[in_sel] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    demux_chan_buf #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
    ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[i]),
      .wr_data (in_data),
      .rd_ready(out_ready[i]),
      .full    (out_valid[i]),
      .data    (out_data[ch_lsb(i, WIDTH) +: WIDTH]),
      .cnt     (xfer_cnt[ch_lsb(i, CNT_W) +: CNT_W])
    );
  end

endmodule

// File: tb/tb_demux_1to4.sv
// tb/tb_demux_1to4.sv - directed scoreboard bench for demux_1to4
module tb_demux_1to4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] xfer_cnt;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_q [4][$];
  logic [7:0] cnt_m [4];

  demux_1to4 #(.WIDTH(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  // Scoreboard: predicts the upcoming edge from the model, then compares the DUT state.
  always @(negedge clk) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        exp_q[c].delete();
        cnt_m[c] = 8'd0;
      end
    end else begin
      chk("in_ready_model", 32'(in_ready),
          32'(exp_q[in_sel].size() == 0 || out_ready[in_sel]));
      for (int c = 0; c < 4; c++) begin
        chk("valid_model", 32'(out_valid[c]), 32'(exp_q[c].size() != 0));
        chk("cnt_model", 32'(xfer_cnt[c*8 +: 8]), 32'(cnt_m[c]));
        if (exp_q[c].size() != 0 && out_ready[c]) begin
          chk("data_model", 32'(out_data[c*4 +: 4]), 32'(exp_q[c].pop_front()));
          cnt_m[c] = cnt_m[c] + 8'd1;
        end
      end
      if (in_valid && (exp_q[in_sel].size() == 0 || out_ready[in_sel])) begin
        exp_q[in_sel].push_back(in_data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    out_ready = 4'b0000;
    drive(1'b1, 2'd0, 4'h0);
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_cnt", xfer_cnt, 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;
    drive(1'b0, 2'd0, 4'h0);
    tick();

    // single word to ch2
    out_ready = 4'b1111;
    drive(1'b1, 2'd2, 4'hA);
    tick();
    drive(1'b0, 2'd0, 4'h0);
    chk("ch2_valid", 32'(out_valid), 32'h4);
    chk("ch2_data", 32'(out_data[11:8]), 32'hA);
    tick();
    chk("ch2_drained", 32'(out_valid), 32'h0);
    chk("ch2_cnt", 32'(xfer_cnt[23:16]), 32'd1);

    // ch1 back-pressure
    out_ready = 4'b1101;
    drive(1'b1, 2'd1, 4'h3);
    #1 chk("ch1_first_ready", 32'(in_ready), 32'h1);
    tick();
    drive(1'b1, 2'd1, 4'h5);
    #1 chk("ch1_stall_ready", 32'(in_ready), 32'h0);
    chk("ch1_hold3", 32'(out_data[7:4]), 32'h3);
    tick();
    chk("ch1_still3", 32'(out_data[7:4]), 32'h3);
    chk("ch1_still_valid", 32'(out_valid[1]), 32'h1);
    out_ready = 4'b1111;
    #1 chk("ch1_release_ready", 32'(in_ready), 32'h1);
    tick();
    chk("ch1_data5", 32'(out_data[7:4]), 32'h5);
    chk("ch1_valid5", 32'(out_valid[1]), 32'h1);
    drive(1'b0, 2'd0, 4'h0);
    tick();
    chk("ch1_empty", 32'(out_valid[1]), 32'h0);

    // ch0 stalled does not block ch3
    out_ready = 4'b1110;
    drive(1'b1, 2'd0, 4'h9);
    tick();
    drive(1'b1, 2'd3, 4'h7);
    #1 chk("ch3_ready", 32'(in_ready), 32'h1);
    tick();
    drive(1'b0, 2'd0, 4'h0);
    chk("ch3_valid", 32'(out_valid), 32'h9);
    chk("ch3_data", 32'(out_data[15:12]), 32'h7);
    chk("ch0_held", 32'(out_data[3:0]), 32'h9);
    tick();
    chk("ch3_drained", 32'(out_valid), 32'h1);
    chk("ch3_last", 32'(out_data[15:12]), 32'h7);
    out_ready = 4'b1111;
    tick();
    chk("ch0_drained", 32'(out_valid), 32'h0);
    chk("ch0_last", 32'(out_data[3:0]), 32'h9);

    // ch1 streaming one word per cycle
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'd1, 4'(i + 1));
      #1 chk("stream_ready", 32'(in_ready), 32'h1);
      tick();
      chk("stream_data", 32'(out_data[7:4]), 32'(i + 1));
      if (i >= 1) chk("stream_cnt", 32'(xfer_cnt[15:8]), 32'(2 + i));
    end
    drive(1'b0, 2'd0, 4'h0);
    tick();

    // reset with ch0 and ch2 loaded
    out_ready = 4'b0000;
    drive(1'b1, 2'd0, 4'h1);
    tick();
    drive(1'b1, 2'd2, 4'h2);
    tick();
    chk("pre_rst_valid", 32'(out_valid), 32'h5);
    rst = 1'b1;
    drive(1'b1, 2'd0, 4'h0);
    #1 chk("in_rst_ready", 32'(in_ready), 32'h0);
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'h0);
    chk("post_rst_data", 32'(out_data), 32'h0);
    chk("post_rst_cnt", xfer_cnt, 32'h0);
    rst = 1'b0;
    #1 chk("after_rst_ready", 32'(in_ready), 32'h1);

    // counter wrap on ch0
    out_ready = 4'b1111;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 2'd0, 4'(i));
      tick();
    end
    drive(1'b0, 2'd0, 4'h0);
    chk("wrap_255", 32'(xfer_cnt[7:0]), 32'hFF);
    tick();
    chk("wrap_256", 32'(xfer_cnt[7:0]), 32'h00);
    chk("wrap_empty", 32'(out_valid), 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
